pwm_multi: RTL and testbench

- Multi-channel PWM generator; successor to the single-channel motor-control PWM.
- One shared prescaler and step counter drive CHANNELS compare outputs.
- Per-channel duty is double-buffered: written through a shadow register, applied at period boundaries.
- Adds a full-on duty code, edge/centre-aligned mode, per-channel output inversion and a period_start strobe; feeds the motor driver pins.

---
 rtl/pwm_multi.sv | 103 ++++++++++
 tb/tb_pwm_multi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared prescaler/step counter, double-buffered duty per
// channel, edge or centre alignment, per-channel inversion, period_start strobe.
module pwm_multi #(
    parameter int CLOCK      = 50000000,
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int CHUNK_SIZE = CLOCK / (2**WIDTH),
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW        = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                center,
    input  logic [CHANNELS-1:0] inv,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH:0]      wr_data,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH:0]   FULL = {1'b1, {WIDTH{1'b0}}};

    logic [PW-1:0]                   r_pre;
    logic [WIDTH-1:0]                r_step;
    logic                            r_down;
    logic                            r_run;
    logic                            r_act_ctr;
    logic [CHANNELS-1:0]             r_act_inv;
    logic [CHANNELS-1:0][WIDTH:0]    r_shadow;
    logic [CHANNELS-1:0][WIDTH:0]    r_act_duty;

    logic                w_tick;
    logic                w_last;
    logic                w_bound;
    logic                w_start;
    logic [WIDTH:0]      w_wr_sat;
    logic [CHANNELS-1:0] w_raw;

    assign w_tick   = (r_pre == PW'(CHUNK_SIZE - 1));
    assign w_last   = r_act_ctr ? (r_down && (r_step == WIDTH'(1))) : (r_step == MAX);
    assign w_bound  = w_tick && w_last;
    assign w_start  = en && !r_run;
    assign w_wr_sat = (wr_data > FULL) ? FULL : wr_data;

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < CHANNELS; i++)
            w_raw[i] = ({1'b0, r_step} < r_act_duty[i]);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_shadow <= '0;
        else if (wr_en && (32'(wr_ch) < CHANNELS))
            r_shadow[wr_ch] <= w_wr_sat;
    end

    // Idle, the first enabled clock and the period boundary all (re)start a
    // period and load the active settings; the shadow value read is the pre-edge one.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pre        <= '0;
            r_step       <= '0;
            r_down       <= 1'b0;
            r_run        <= 1'b0;
            r_act_ctr    <= 1'b0;
            r_act_inv    <= '0;
            r_act_duty   <= '0;
            pwm          <= '0;
            period_start <= 1'b0;
        end else begin
            r_run        <= en;
            period_start <= en && (w_start || w_bound);
            if (!en || w_start || w_bound) begin
                r_pre      <= '0;
                r_step     <= '0;
                r_down     <= 1'b0;
                r_act_duty <= r_shadow;
                r_act_ctr  <= center;
                r_act_inv  <= inv;
            end else if (w_tick) begin
                r_pre <= '0;
                if (r_down) begin
                    r_step <= r_step - 1'b1;
                end else if (r_act_ctr && (r_step == MAX)) begin
                    r_step <= MAX - 1'b1;
                    r_down <= 1'b1;
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            // The starting clock still shows the idle level so every period's
            // waveform lines up one clock after period_start.
            pwm <= (en && !w_start) ? (w_raw ^ r_act_inv) : r_act_inv;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-offset reference model predicts every
// clock's outputs; a monitor pops and compares, and logs per-period pwm[0] stats.
module tb_pwm_multi;

    localparam int W    = 4;
    localparam int CH   = 4;
    localparam int NC   = 4;
    localparam int MAX  = 15;
    localparam int FULL = 16;

    typedef struct packed {
        logic [NC-1:0] pwm;
        logic          ps;
    } exp_t;

    typedef struct {
        int len;
        int hi;
    } per_t;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          en = 1'b0;
    logic          center = 1'b0;
    logic [NC-1:0] inv = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [W:0]    wr_data = '0;
    logic [NC-1:0] pwm;
    logic          period_start;

    pwm_multi #(.CLOCK(64), .WIDTH(W), .CHANNELS(NC), .CHUNK_SIZE(CH)) dut (
        .clk(clk), .clr(clr), .en(en), .center(center), .inv(inv),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .pwm(pwm), .period_start(period_start)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    per_t per_log[$];

    // Reference model: position within the current period plus the settings latched for it.
    int        m_shadow[NC];
    int        m_duty[NC];
    bit [NC-1:0] m_inv;
    bit        m_ctr;
    bit        m_run;
    int        m_off;

    function automatic int m_len();
        return m_ctr ? 2 * MAX * CH : (MAX + 1) * CH;
    endfunction

    function automatic bit lvl(int ch, int off);
        int s;
        s = off / CH;
        if (m_ctr && s > MAX) s = 2 * MAX - s;
        return ((s < m_duty[ch]) ? 1'b1 : 1'b0) ^ m_inv[ch];
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NC; i++) begin
            m_shadow[i] = 0;
            m_duty[i]   = 0;
        end
        m_inv = '0;
        m_ctr = 1'b0;
        m_run = 1'b0;
        m_off = 0;
    endfunction

    function automatic void m_load();
        for (int i = 0; i < NC; i++) m_duty[i] = m_shadow[i];
        m_ctr = center;
        m_inv = inv;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    // One clock: predict the outputs the coming edge produces, queue them.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        e = '0;
        if (clr) begin
            m_reset();
        end else begin
            for (int i = 0; i < NC; i++)
                e.pwm[i] = (en && m_run) ? lvl(i, m_off) : m_inv[i];
            if (!en) begin
                m_load();
                m_run = 1'b0;
                m_off = 0;
            end else if (!m_run || m_off == m_len() - 1) begin
                m_load();
                m_run = 1'b1;
                m_off = 0;
                e.ps  = 1'b1;
            end else begin
                m_off++;
            end
            if (wr_en && int'(wr_ch) < NC)
                m_shadow[wr_ch] = (int'(wr_data) > FULL) ? FULL : int'(wr_data);
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_data = 5'(data);
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic run_to_boundary();
        int guard;
        guard = 0;
        while (m_off != m_len() - 1 && guard < 300) begin
            cyc();
            guard++;
        end
        chk("boundary reached", (guard < 300) ? 1 : 0, 1);
    endtask

    task automatic chk_period(input int idx, input int len, input int hi);
        if (per_log.size() <= idx) begin
            chk("period logged", 0, 1);
        end else begin
            chk("period length", per_log[idx].len, len);
            chk("pwm0 high clocks", per_log[idx].hi, hi);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   p_len;
        int   p_hi;
        p_len = 0;
        p_hi  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pwm", 32'(pwm), 32'(e.pwm));
                chk("period_start", 32'(period_start), 32'(e.ps));
            end
            p_len++;
            p_hi += int'(pwm[0]);
            if (period_start) begin
                per_log.push_back('{p_len, p_hi});
                p_len = 0;
                p_hi  = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        m_reset();
        #2;
        chk("reset pwm", 32'(pwm), 0);
        chk("reset period_start", 32'(period_start), 0);
        repeat (3) cyc();
        clr = 1'b0;

        // Duties 5 / 0 / 16 / 20 (saturates), then edge-aligned run
        write(0, 5);
        write(1, 0);
        write(2, 16);
        write(3, 20);
        en = 1'b1;
        cyc();
        per_log.delete();
        repeat (128) cyc();
        chk_period(0, 64, 20);
        chk_period(1, 64, 20);
        chk("ch1..3 levels", 32'(pwm[3:1]), 32'b110);

        // Mid-period write 8, then 3 exactly on the boundary clock
        per_log.delete();
        repeat (10) cyc();
        write(0, 8);
        run_to_boundary();
        write(0, 3);
        repeat (128) cyc();
        chk_period(0, 64, 20);
        chk_period(1, 64, 32);
        chk_period(2, 64, 12);

        // Centre-aligned, duty 5
        center = 1'b1;
        write(0, 5);
        run_to_boundary();
        cyc();
        per_log.delete();
        repeat (240) cyc();
        chk_period(0, 120, 36);
        chk_period(1, 120, 36);

        // Inverted edge mode, then drop en
        center = 1'b0;
        inv    = 4'b0001;
        run_to_boundary();
        cyc();
        per_log.delete();
        repeat (64) cyc();
        chk_period(0, 64, 44);
        repeat (5) cyc();
        en = 1'b0;
        cyc();
        chk("idle inverted level", 32'(pwm[0]), 1);
        chk("idle period_start", 32'(period_start), 0);

        // Async clear mid-high phase, then restart matches the first run
        inv = '0;
        en  = 1'b1;
        repeat (11) cyc();
        chk("pwm0 high before clr", 32'(pwm[0]), 1);
        #1 clr = 1'b1;
        #1;
        chk("async clr pwm", 32'(pwm), 0);
        chk("async clr period_start", 32'(period_start), 0);
        repeat (3) cyc();
        clr = 1'b0;
        en  = 1'b0;
        write(0, 5);
        en = 1'b1;
        cyc();
        per_log.delete();
        repeat (128) cyc();
        chk_period(0, 64, 20);
        chk_period(1, 64, 20);

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) center = ~center;
            if ($urandom_range(0, 149) == 0) inv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) en = ~en;
            cyc();
        end
        wr_en = 1'b0;
        en    = 1'b0;
        repeat (4) cyc();
        chk("scoreboard drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
